data_memory_responder: RTL and testbench

//  Data-memory end of the execute-stage load/store interface. Accepts the EX stage's

---
 rtl/dmem_pkg.sv | 29 ++
 rtl/data_memory_responder_if.sv | 23 ++
 rtl/dmem_array.sv | 25 ++
 rtl/data_memory_responder.sv | 108 ++++++++++
 tb/tb_data_memory_responder.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: FSM states, latched
// operation kinds and the wait-counter width.
package dmem_pkg;

  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    HOLD
  } state_e;

  typedef enum logic [1:0] {
    OP_RD,
    OP_WR,
    OP_BAD
  } op_e;

  // Conflicting strobes, and offsets past the array (below-base offsets wrap huge),
  // are rejected.
  function automatic op_e decode_op(input logic rd, input logic wr,
                                    input logic [31:0] offset, input logic [31:0] depth);
    if ((rd && wr) || (offset >= depth)) return OP_BAD;
    else if (wr) return OP_WR;
    else return OP_RD;
  endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// Load/store bus between the EX stage (master) and the data-memory responder (slave).
interface data_memory_responder_if;
  // Handshake: the master raises read or write as a level with address and data stable
  // at acceptance; the slave answers with exactly one ready pulse (fault alongside it when
  // rejected) and re-arms only after both strobes have been seen low.
  logic [31:0] data_memory_a;
  logic [31:0] data_memory_out_v;
  logic        data_memory_read;
  logic        data_memory_write;
  logic [31:0] data_memory_in_v;
  logic        data_memory_ready;
  logic        data_memory_fault;

  modport master (
    output data_memory_a, data_memory_out_v, data_memory_read, data_memory_write,
    input  data_memory_in_v, data_memory_ready, data_memory_fault
  );

  modport slave (
    input  data_memory_a, data_memory_out_v, data_memory_read, data_memory_write,
    output data_memory_in_v, data_memory_ready, data_memory_fault
  );
endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with a registered one-cycle read; storage is never
// reset. The read register holds its value until the next read enable.
module dmem_array #(
  parameter int  DEPTH_WORDS = 1024,
  localparam int IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory end of the EX load/store interface: latches one request per strobe,
// waits WAIT_STATES cycles, accesses the array (or rejects) and pulses ready.
module data_memory_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          WAIT_STATES = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  data_memory_responder_if.slave          bus,
  output state_e                          dbg_state_o
);

  localparam int                IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0]       DEPTH32   = 32'(DEPTH_WORDS);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_STATES);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  op_e               op_q, op_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              zero_q, zero_d;

  logic [31:0] offset;
  logic        strobe;
  logic        access;
  logic        ram_we;
  logic        ram_re;
  logic [31:0] ram_rdata;

  assign offset = bus.data_memory_a - BASE_ADDR;
  assign strobe = bus.data_memory_read | bus.data_memory_write;
  assign access = (state_q == WAIT) && (cnt_q == '0);
  // A reset on the access edge must leave the array untouched.
  assign ram_we = access && (op_q == OP_WR) && !reset;
  assign ram_re = access && (op_q == OP_RD) && !reset;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (strobe) begin
          op_d    = decode_op(bus.data_memory_read, bus.data_memory_write, offset, DEPTH32);
          idx_d   = offset[IDX_W-1:0];
          wdata_d = bus.data_memory_out_v;
          cnt_d   = WAIT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = RESP;
          // zero_q masks the RAM read register: set by a fault, cleared by a read.
          if (op_q == OP_BAD)     zero_d = 1'b1;
          else if (op_q == OP_RD) zero_d = 1'b0;
        end
      end
      RESP:    state_d = HOLD;
      HOLD:    if (!strobe) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_RD;
      idx_q   <= '0;
      wdata_q <= '0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      zero_q  <= zero_d;
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .idx_i   (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  assign bus.data_memory_ready = (state_q == RESP);
  assign bus.data_memory_fault = (state_q == RESP) && (op_q == OP_BAD);
  assign bus.data_memory_in_v  = zero_q ? 32'h0 : ram_rdata;
  assign dbg_state_o           = state_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: one instance with BASE 0 / one wait state,
// one with BASE 0x100 / 16 words / no wait states, sharing a single driver.
module tb_data_memory_responder;
  import dmem_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  data_memory_responder_if if0();
  data_memory_responder_if if1();
  state_e st0, st1;

  logic        rd_r, wr_r;
  logic [31:0] a_r, d_r;
  int          sel;

  assign if0.data_memory_a     = a_r;
  assign if0.data_memory_out_v = d_r;
  assign if0.data_memory_read  = rd_r & (sel == 0);
  assign if0.data_memory_write = wr_r & (sel == 0);
  assign if1.data_memory_a     = a_r;
  assign if1.data_memory_out_v = d_r;
  assign if1.data_memory_read  = rd_r & (sel == 1);
  assign if1.data_memory_write = wr_r & (sel == 1);

  data_memory_responder #(
    .DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(1)
  ) dut0 (
    .clk(clk), .reset(reset), .bus(if0.slave), .dbg_state_o(st0)
  );

  data_memory_responder #(
    .DEPTH_WORDS(16), .BASE_ADDR(32'h100), .WAIT_STATES(0)
  ) dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave), .dbg_state_o(st1)
  );

  logic        ready_w, fault_w;
  logic [31:0] in_v_w;
  state_e      st_w;
  assign ready_w = (sel == 0) ? if0.data_memory_ready : if1.data_memory_ready;
  assign fault_w = (sel == 0) ? if0.data_memory_fault : if1.data_memory_fault;
  assign in_v_w  = (sel == 0) ? if0.data_memory_in_v  : if1.data_memory_in_v;
  assign st_w    = (sel == 0) ? st0 : st1;

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge; the following posedge is the acceptance edge. Strobes stay high
  // for `hold` negedges, address/data are scrambled right after acceptance.
  task automatic request(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] data, input int hold,
                         output logic [31:0] rdat, output logic flt,
                         output int lat, output int pulses);
    int w;
    int n_end;
    w     = (sel == 0) ? 1 : 0;
    n_end = ((hold > w + 3) ? hold : w + 3) + 1;
    rd_r = rd; wr_r = wr; a_r = addr; d_r = data;
    lat = -1; pulses = 0; rdat = '0; flt = 1'b0;
    for (int n = 1; n <= n_end; n++) begin
      @(negedge clk);
      if (ready_w) begin
        pulses++;
        if (lat < 0) begin
          lat  = n;
          rdat = in_v_w;
          flt  = fault_w;
        end
      end
      if (n == 1) begin a_r = ~addr; d_r = ~data; end
      if (n == hold) begin rd_r = 1'b0; wr_r = 1'b0; end
    end
    rd_r = 1'b0; wr_r = 1'b0;
  endtask

  function automatic int exp_lat();
    return (sel == 0) ? 3 : 2;
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic exp_flt, input string tag);
    logic [31:0] rdat; logic flt; int lat; int pulses;
    request(1'b0, 1'b1, addr, data, 1, rdat, flt, lat, pulses);
    check({tag, "_lat"},    32'(lat),    32'(exp_lat()));
    check({tag, "_fault"},  32'(flt),    32'(exp_flt));
    check({tag, "_pulses"}, 32'(pulses), 32'd1);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic exp_flt, input int hold, input string tag);
    logic [31:0] rdat; logic flt; int lat; int pulses;
    exp_q.push_back(exp_data);
    request(1'b1, 1'b0, addr, 32'h0, hold, rdat, flt, lat, pulses);
    check({tag, "_lat"},    32'(lat),    32'(exp_lat()));
    check({tag, "_fault"},  32'(flt),    32'(exp_flt));
    check({tag, "_pulses"}, 32'(pulses), 32'd1);
    check({tag, "_data"},   rdat,        exp_q.pop_front());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rdat; logic flt; int lat; int pulses;
    reset = 1'b1; sel = 0; rd_r = 1'b0; wr_r = 1'b0; a_r = '0; d_r = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      check($sformatf("rst%0d_ready", s), 32'(ready_w), 32'd0);
      check($sformatf("rst%0d_fault", s), 32'(fault_w), 32'd0);
      check($sformatf("rst%0d_inv", s),   in_v_w,       32'd0);
      check($sformatf("rst%0d_state", s), 32'(st_w),    32'(IDLE));
    end
    sel = 0;
    @(negedge clk);

    // Basic write then read, one wait state.
    do_write(32'd5, 32'hDEADBEEF, 1'b0, "wr5");
    do_read (32'd5, 32'hDEADBEEF, 1'b0, 1, "rd5");
    do_write(32'd6, 32'h0000600D, 1'b0, "wr6");
    check("inv_after_wr", in_v_w, 32'hDEADBEEF);

    // Held strobe gives one pulse; re-raise after one low edge gives another.
    do_read(32'd5, 32'hDEADBEEF, 1'b0, 20, "hold20");
    do_read(32'd6, 32'h0000600D, 1'b0, 1,  "reraise");

    // Upper boundary and index truncation after the range check.
    do_write(32'd1023, 32'hA5A5A5A5, 1'b0, "wr1023");
    do_read (32'd1023, 32'hA5A5A5A5, 1'b0, 1, "rd1023");
    do_write(32'd0,    32'h00000011, 1'b0, "wr0");
    do_read (32'd1024, 32'h0,        1'b1, 1, "rd1024");
    do_write(32'd1024, 32'h00000BAD, 1'b1, "wr1024");
    do_read (32'd0,    32'h00000011, 1'b0, 1, "rd0");

    // Conflicting strobes fault and leave the word alone.
    do_write(32'd7, 32'h00000077, 1'b0, "wr7");
    do_read (32'd5, 32'hDEADBEEF, 1'b0, 1, "rd5b");
    request(1'b1, 1'b1, 32'd7, 32'hFFFF, 1, rdat, flt, lat, pulses);
    check("both_lat",   32'(lat), 32'd3);
    check("both_fault", 32'(flt), 32'd1);
    check("both_inv",   rdat,     32'd0);
    do_read(32'd7, 32'h00000077, 1'b0, 1, "rd7");

    // Reset landing on the access edge of a write.
    do_write(32'd9, 32'h00005555, 1'b0, "wr9");
    wr_r = 1'b1; a_r = 32'd9; d_r = 32'h1234;
    @(negedge clk);
    check("rstmid_wait", 32'(st0), 32'(WAIT));
    @(negedge clk);
    reset = 1'b1; wr_r = 1'b0;
    @(negedge clk);
    check("rstmid_noready", 32'(ready_w), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rstmid_ready", 32'(ready_w), 32'd0);
    check("rstmid_fault", 32'(fault_w), 32'd0);
    check("rstmid_inv",   in_v_w,       32'd0);
    check("rstmid_state", 32'(st0),     32'(IDLE));
    do_read(32'd9, 32'h00005555, 1'b0, 1, "rd9");

    // Offset base, 16 words, zero wait states.
    sel = 1;
    @(negedge clk);
    do_read (32'h0FF, 32'h0,        1'b1, 1, "b_rdff");
    do_write(32'h100, 32'h0000CAFE, 1'b0, "b_wr100");
    do_read (32'h100, 32'h0000CAFE, 1'b0, 1, "b_rd100");
    do_write(32'h10F, 32'h0000F00D, 1'b0, "b_wr10f");
    do_read (32'h10F, 32'h0000F00D, 1'b0, 1, "b_rd10f");
    do_read (32'h110, 32'h0,        1'b1, 1, "b_rd110");
    do_write(32'h110, 32'h00000BAD, 1'b1, "b_wr110");
    do_read (32'h000, 32'h0,        1'b1, 1, "b_rd000");
    do_read (32'h100, 32'h0000CAFE, 1'b0, 3, "b_rd100b");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
